cas_tape_player: RTL
====================

// Module: cas_tape_player
// PURPOSE
//  Tape playback engine for the cassette overlay. It reads tape-image bytes from a
//  memory port, one byte at a time, and shifts each byte out MSB-first as the
//  cassette bit stream cas_out. Its pos, max and tape_data outputs drive the
//  overlay's pos, max and tape_data inputs; pos changes exactly once per byte.
// PARAMETERS
//  BIT_CYCLES  1136  i_clk cycles each bit is held on cas_out (>=2)
//  AW          25    width of pos, max, tape_len and mem_addr
// PORTS
//  i_clk          in   1   clock; all logic on the rising edge
//  reset          in   1   synchronous, active-high
//  play           in   1   level: 1 = run, 0 = pause at the next byte boundary
//  rewind         in   1   pulse: abort playback and return to byte 0
//  tape_len       in   AW  tape length in bytes
//  tape_len_valid in   1   pulse: latch tape_len into max; implies rewind
//  mem_addr       out  AW  byte address of the read request (= pos)
//  mem_rd         out  1   read request; held high until mem_ack
//  mem_ack        in   1   read complete; mem_data is valid in the same cycle
//  mem_data       in   8   read data
//  pos            out  AW  index of the byte currently playing or last played
//  max            out  AW  latched tape length
//  tape_data      out  8   byte currently being shifted out
//  cas_out        out  1   serial cassette bit
//  eof            out  1   end of tape reached
// BEHAVIOUR
//  Reset: state=IDLE; pos=0, max=0, tape_data=0, cas_out=0, mem_rd=0, eof=0, mem_addr=0.
//  Priority each cycle: reset > rewind/tape_len_valid > state machine.
//  rewind: pos=0, eof=0, mem_rd=0, cas_out=0, state=IDLE; max and tape_data unchanged.
//   Any outstanding request is abandoned; a mem_ack arriving in that cycle is ignored.
//  tape_len_valid: same as rewind, and max<=tape_len. If both pulses assert together,
//   both apply and max is loaded.
//  States:
//   IDLE: if play && max!=0 && !eof -> FETCH; mem_rd<=1 and mem_addr<=pos.
//         Latency: play sampled high in cycle N gives mem_rd=1 in cycle N+1.
//   FETCH: mem_rd and mem_addr stay stable until mem_ack. On ack: tape_data<=mem_data,
//         shreg<=mem_data, mem_rd<=0, bitcnt=0, divcnt=0 -> SHIFT.
//         play is not sampled in FETCH; an issued fetch always completes.
//   SHIFT: cas_out=shreg[7] from the cycle after ack. divcnt runs 0..BIT_CYCLES-1; at the
//         wrap, shreg<<=1 and bitcnt++. After 8 bits (8*BIT_CYCLES cycles) the byte ends:
//          - pos+1==max: -> DONE, eof<=1, cas_out<=0, pos unchanged (last byte index)
//          - else pos<=pos+1; if play: -> FETCH with mem_rd<=1, mem_addr<=pos+1;
//            else -> IDLE
//         Dropping play mid-byte finishes the current byte, then enters IDLE.
//   DONE: hold all outputs; leave only on rewind, tape_len_valid or reset.
//  mem_ack while mem_rd=0 is ignored. pos arithmetic is AW bits wide with no wrap;
//   pos < max always holds. max=0 never starts playback.
//  cas_out is 0 in IDLE, FETCH (between bytes) and DONE.
// CONFIGURATION
//  TAPE_LOOP_EN defined: at end of the last byte, pos<=0, eof stays 0 and playback
//   continues with FETCH of address 0 if play=1, or goes to IDLE otherwise. DONE is
//   unreachable, so the overlay sees pos==0 and resets its progress bar.
//  TAPE_LOOP_EN undefined: behaviour as specified above (stop in DONE, eof=1).
// TESTING (BIT_CYCLES=4, memory returns mem_data=addr+8'hA0 with 2-cycle ack latency)
//  1 reset -> pos=0, max=0, mem_rd=0, cas_out=0, eof=0; play=1 with max=0 -> no mem_rd ever.
//  2 tape_len=3 + valid, play=1 -> reads addr 0,1,2; cas_out carries A0,A1,A2 MSB-first,
//    4 cycles per bit; pos steps 0->1->2; eof=1 with pos=2; no further mem_rd.
//  3 play dropped during bit 3 of byte 0 -> byte completes, pos=1, IDLE, mem_rd stays 0;
//    play=1 again -> mem_addr=1 next cycle.
//  4 rewind during FETCH of addr 1 with ack in the same cycle -> ack ignored, pos=0,
//    tape_data unchanged, mem_rd=0 next cycle.
//  5 rewind and tape_len_valid(tape_len=5) in the same cycle, from DONE -> max=5, pos=0,
//    eof=0; replay starts from addr 0.
//  6 TAPE_LOOP_EN, tape_len=2, play=1 -> addresses 0,1,0,1...; pos 0,1,0,1; eof stays 0.

Source files
------------

// File: rtl/cas_tape_player.sv
// Cassette tape playback engine: fetches tape-image bytes and shifts them out MSB-first.
// Define TAPE_LOOP_EN to wrap back to byte 0 at end of tape instead of stopping with eof.
module cas_tape_player #(
    parameter int BIT_CYCLES = 1136,
    parameter int AW         = 25
) (
    input  logic          i_clk,
    input  logic          reset,
    input  logic          play,
    input  logic          rewind,
    input  logic [AW-1:0] tape_len,
    input  logic          tape_len_valid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic          mem_ack,
    input  logic [7:0]    mem_data,
    output logic [AW-1:0] pos,
    output logic [AW-1:0] max,
    output logic [7:0]    tape_data,
    output logic          cas_out,
    output logic          eof
);

    localparam int DW = $clog2(BIT_CYCLES);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pos_q, pos_d;
    logic [AW-1:0] max_q, max_d;
    logic [7:0]    tape_data_q, tape_data_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [DW-1:0] divcnt_q, divcnt_d;
    logic          mem_rd_q, mem_rd_d;
    logic          eof_q, eof_d;
    logic [AW-1:0] pos_inc;

    assign pos_inc = pos_q + AW'(1);

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        max_d       = max_q;
        tape_data_d = tape_data_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        divcnt_d    = divcnt_q;
        mem_rd_d    = mem_rd_q;
        eof_d       = eof_q;
        if (rewind || tape_len_valid) begin
            pos_d    = '0;
            eof_d    = 1'b0;
            mem_rd_d = 1'b0;
            state_d  = S_IDLE;
            if (tape_len_valid) begin
                max_d = tape_len;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (play && (max_q != '0) && !eof_q) begin
                        state_d  = S_FETCH;
                        mem_rd_d = 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        tape_data_d = mem_data;
                        shreg_d     = mem_data;
                        mem_rd_d    = 1'b0;
                        bitcnt_d    = '0;
                        divcnt_d    = '0;
                        state_d     = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (divcnt_q != DIV_LAST) begin
                        divcnt_d = divcnt_q + DW'(1);
                    end else if (bitcnt_q != 3'd7) begin
                        divcnt_d = '0;
                        shreg_d  = {shreg_q[6:0], 1'b0};
                        bitcnt_d = bitcnt_q + 3'd1;
                    end else begin
                        divcnt_d = '0;
                        // Byte boundary: advance, then fetch only if still playing.
                        if (pos_inc == max_q) begin
`ifdef TAPE_LOOP_EN
                            pos_d    = '0;
                            state_d  = play ? S_FETCH : S_IDLE;
                            mem_rd_d = play;
`else
                            state_d  = S_DONE;
                            eof_d    = 1'b1;
`endif
                        end else begin
                            pos_d    = pos_inc;
                            state_d  = play ? S_FETCH : S_IDLE;
                            mem_rd_d = play;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            max_q       <= '0;
            tape_data_q <= '0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            divcnt_q    <= '0;
            mem_rd_q    <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            max_q       <= max_d;
            tape_data_q <= tape_data_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            divcnt_q    <= divcnt_d;
            mem_rd_q    <= mem_rd_d;
            eof_q       <= eof_d;
        end
    end

    assign mem_addr  = pos_q;
    assign mem_rd    = mem_rd_q;
    assign pos       = pos_q;
    assign max       = max_q;
    assign tape_data = tape_data_q;
    assign eof       = eof_q;
    assign cas_out   = (state_q == S_SHIFT) & shreg_q[7];

endmodule
